alarm_dispatcher: RTL

ALARM_DISPATCHER -- requirements
Module: alarm_dispatcher

---
 rtl/alarm_dispatcher.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alarm_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alarm_dispatcher                                                |
// | Brief    : Latches alarm rises, notifies each one over a valid/ready link  |
// |            in fire > burglar > rain order, and drives siren/strobe until   |
// |            acknowledged. ALARM_DISPATCHER_REPEAT_EN adds periodic re-send. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alarm_dispatcher (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alarms,
  input  logic       ack,
  input  logic       msg_ready,
  output logic       msg_valid,
  output logic [1:0] msg_code,
  output logic       siren,
  output logic       strobe,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ALERT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_prev;
  logic [2:0] r_pending;
  logic [2:0] r_notified;
  logic [1:0] r_code;
  logic [1:0] r_siren_cnt;

  logic [2:0] w_rise;
  logic [2:0] w_target;
  logic [1:0] w_tgt_code;
  logic [1:0] w_pend_code;
  logic       w_handshake;
  logic       w_active;
  logic [2:0] w_pending_nxt;
  logic [2:0] w_notified_nxt;
  logic [1:0] w_code_nxt;

`ifdef ALARM_DISPATCHER_REPEAT_EN
  logic [7:0] r_rep_cnt;
`endif

  function automatic logic [1:0] top_code(input logic [2:0] v);
    if (v[2])      top_code = 2'b11;
    else if (v[1]) top_code = 2'b10;
    else if (v[0]) top_code = 2'b01;
    else           top_code = 2'b00;
  endfunction

  function automatic logic [2:0] code_mask(input logic [1:0] c);
    case (c)
      2'b11:   code_mask = 3'b100;
      2'b10:   code_mask = 3'b010;
      2'b01:   code_mask = 3'b001;
      default: code_mask = 3'b000;
    endcase
  endfunction

  assign w_rise      = alarms & ~r_prev;
  assign w_target    = r_pending & ~r_notified;
  assign w_tgt_code  = top_code(w_target);
  assign w_pend_code = top_code(r_pending);
  assign w_handshake = (r_state == ST_SEND) && msg_ready;

  // A fresh rise is a new occurrence: it re-arms notification even if an ack
  // or a handshake for the same bit lands in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending | w_rise;
    w_notified_nxt = r_notified & ~w_rise;
    w_code_nxt     = r_code;
    case (r_state)
      ST_IDLE: begin
        if (|w_target) begin
          w_state_nxt = ST_SEND;
          w_code_nxt  = w_tgt_code;
        end
      end
      ST_SEND: begin
        if (w_handshake) begin
          w_notified_nxt = (r_notified | code_mask(r_code)) & ~w_rise;
          w_state_nxt    = ST_ALERT;
        end
      end
      ST_ALERT: begin
        if (ack) begin
          w_pending_nxt  = (r_pending & alarms) | w_rise;
          w_notified_nxt = r_notified & alarms & ~w_rise;
          if (w_pending_nxt == 3'b000) w_state_nxt = ST_IDLE;
`ifdef ALARM_DISPATCHER_REPEAT_EN
        end else if ((r_rep_cnt == 8'hFF) && (|r_pending)) begin
          w_notified_nxt = 3'b000;
          w_state_nxt    = ST_SEND;
          w_code_nxt     = w_pend_code;
`endif
        end else if (|w_target) begin
          w_state_nxt = ST_SEND;
          w_code_nxt  = w_tgt_code;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev      <= 3'b000;
      r_pending   <= 3'b000;
      r_notified  <= 3'b000;
      r_code      <= 2'b00;
      r_siren_cnt <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= alarms;
      r_pending   <= w_pending_nxt;
      r_notified  <= w_notified_nxt;
      r_code      <= w_code_nxt;
      r_siren_cnt <= r_siren_cnt + 2'd1;
    end
  end

`ifdef ALARM_DISPATCHER_REPEAT_EN
  // Counts only while resting in ALERT with something pending; any exit,
  // entry or ack restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt <= 8'd0;
    end else if ((r_state != ST_ALERT) || (w_state_nxt != ST_ALERT) || ack) begin
      r_rep_cnt <= 8'd0;
    end else if (|r_pending) begin
      r_rep_cnt <= r_rep_cnt + 8'd1;
    end
  end
`endif

  assign msg_valid = (r_state == ST_SEND);
  assign msg_code  = msg_valid ? r_code : 2'b00;
  assign pending   = r_pending;
  assign w_active  = (r_state != ST_IDLE) && (|r_pending);

  always_comb begin
    siren  = 1'b0;
    strobe = 1'b0;
    if (w_active) begin
      strobe = 1'b1;
      case (w_pend_code)
        2'b11:   siren = 1'b1;
        2'b10:   siren = r_siren_cnt[1];
        default: siren = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
